// File: rtl/systolic_mac_pe_pkg.sv
// Shared definitions for the systolic MAC processing element: operand and
// product widths, default window geometry, window FSM encodings and the
// 2x2 / 4x4 building blocks of the vedic multiplier.
package systolic_mac_pe_pkg;

  localparam int OPERAND_W     = 8;
  localparam int PROD_W        = 16;
  localparam int ACC_W_DEFAULT = 24;
  localparam int K_LEN_DEFAULT = 9;

  // Window FSM encodings
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  typedef logic [OPERAND_W-1:0] operand_t;
  typedef logic [PROD_W-1:0]    prod_t;

  // Urdhva-tiryagbhyam 2x2 cell: vertical and crosswise partial products.
  function automatic logic [3:0] vedic2(input logic [1:0] a, input logic [1:0] b);
    logic [3:0] r;
    logic       x;
    logic       y;
    logic       z;
    logic       c1;
    x    = a[1] & b[0];
    y    = a[0] & b[1];
    z    = a[1] & b[1];
    c1   = x & y;
    r[0] = a[0] & b[0];
    r[1] = x ^ y;
    r[2] = z ^ c1;
    r[3] = z & c1;
    return r;
  endfunction

  // 4x4 product assembled from four 2x2 cells.
  function automatic logic [7:0] vedic4(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] ll;
    logic [3:0] lh;
    logic [3:0] hl;
    logic [3:0] hh;
    ll = vedic2(a[1:0], b[1:0]);
    lh = vedic2(a[1:0], b[3:2]);
    hl = vedic2(a[3:2], b[1:0]);
    hh = vedic2(a[3:2], b[3:2]);
    return {hh, 4'b0000} + {2'b00, lh, 2'b00} + {2'b00, hl, 2'b00} + {4'b0000, ll};
  endfunction

endpackage

// File: rtl/systolic_mac_pe_vedic.sv
// Combinational 8x8 unsigned vedic multiplier built from four 4x4 cells.
module systolic_mac_pe_vedic
  import systolic_mac_pe_pkg::*;
(
  input  operand_t a,
  input  operand_t b,
  output prod_t    p
);

  logic [7:0] ll;
  logic [7:0] lh;
  logic [7:0] hl;
  logic [7:0] hh;

  assign ll = vedic4(a[3:0], b[3:0]);
  assign lh = vedic4(a[3:0], b[7:4]);
  assign hl = vedic4(a[7:4], b[3:0]);
  assign hh = vedic4(a[7:4], b[7:4]);

  assign p = {hh, 8'h00} + {4'h0, lh, 4'h0} + {4'h0, hl, 4'h0} + {8'h00, ll};

endmodule

// File: rtl/systolic_mac_pe.sv
// Output-stationary systolic MAC processing element.
// Forwards pixel (west->east) and weight (north->south) operands with one
// cycle of latency, multiplies paired operands and accumulates K_LEN products
// into a saturating window sum.
//
// Window FSM
//   state   | meaning
//   --------+--------------------------------------------------------------
//   ST_IDLE | no term of the current window accumulated yet (cnt=0, acc=0)
//   ST_RUN  | window in progress, 1..K_LEN-1 terms accumulated
module systolic_mac_pe
  import systolic_mac_pe_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEFAULT,
  parameter int K_LEN = K_LEN_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic [7:0]       a_in,
  input  logic             a_valid_in,
  input  logic [7:0]       b_in,
  input  logic             b_valid_in,
  output logic [7:0]       a_out,
  output logic             a_valid_out,
  output logic [7:0]       b_out,
  output logic             b_valid_out,
  output logic [ACC_W-1:0] acc_out,
  output logic             acc_valid,
  output logic             overflow,
  output logic             misalign
);

  localparam int               CNT_W    = $clog2(K_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(K_LEN);
  localparam logic [ACC_W-1:0] ACC_MAX  = '1;

  operand_t         a_reg;
  operand_t         b_reg;
  logic             v1;
  logic             v2;
  prod_t            prod_mul;
  prod_t            prod_reg;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             sat;
  logic [0:0]       state;

  logic [ACC_W-1:0] acc_base;
  logic [ACC_W:0]   sum_wide;
  logic             sum_over;
  logic [ACC_W-1:0] sum_sat;
  logic [CNT_W-1:0] cnt_next;
  logic             last_term;

  assign a_out = a_reg;
  assign b_out = b_reg;

  // Forwarding registers: always sample, independent of pairing or clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg       <= '0;
      b_reg       <= '0;
      a_valid_out <= 1'b0;
      b_valid_out <= 1'b0;
    end else begin
      a_reg       <= a_in;
      b_reg       <= b_in;
      a_valid_out <= a_valid_in;
      b_valid_out <= b_valid_in;
    end
  end

  // Stage 1 qualifier and sticky misalignment flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1       <= 1'b0;
      misalign <= 1'b0;
    end else if (clear) begin
      v1       <= 1'b0;
      misalign <= 1'b0;
    end else begin
      v1 <= a_valid_in & b_valid_in;
      if (a_valid_in != b_valid_in) begin
        misalign <= 1'b1;
      end
    end
  end

  systolic_mac_pe_vedic u_vedic_multu8 (
    .a (a_reg),
    .b (b_reg),
    .p (prod_mul)
  );

  // Stage 2: capture the product only for paired operands; bubbles hold it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_reg <= '0;
      v2       <= 1'b0;
    end else if (clear) begin
      v2 <= 1'b0;
    end else begin
      v2 <= v1;
      if (v1) begin
        prod_reg <= prod_mul;
      end
    end
  end

  // Saturating add and window count; IDLE implies an empty accumulator.
  always_comb begin
    acc_base  = (state == ST_IDLE) ? '0 : acc;
    sum_wide  = {1'b0, acc_base} + (ACC_W + 1)'(prod_reg);
    sum_over  = sum_wide[ACC_W];
    sum_sat   = sum_over ? ACC_MAX : sum_wide[ACC_W-1:0];
    cnt_next  = (state == ST_IDLE) ? CNT_W'(1) : cnt + CNT_W'(1);
    last_term = (cnt_next == CNT_LAST);
  end

  // Stage 3: accumulate, close the window on the K_LEN-th term.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      cnt       <= '0;
      sat       <= 1'b0;
      state     <= ST_IDLE;
      acc_out   <= '0;
      acc_valid <= 1'b0;
      overflow  <= 1'b0;
    end else if (clear) begin
      acc       <= '0;
      cnt       <= '0;
      sat       <= 1'b0;
      state     <= ST_IDLE;
      acc_valid <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      acc_valid <= 1'b0;
      if (v2) begin
        if (last_term) begin
          acc_out   <= sum_sat;
          acc_valid <= 1'b1;
          acc       <= '0;
          cnt       <= '0;
          sat       <= 1'b0;
          state     <= ST_IDLE;
          overflow  <= overflow | sat | sum_over;
        end else begin
          acc   <= sum_sat;
          cnt   <= cnt_next;
          sat   <= sat | sum_over;
          state <= ST_RUN;
        end
      end
    end
  end

endmodule

// File: tb/tb_systolic_mac_pe.sv
// Directed bench for systolic_mac_pe: default geometry instance plus a
// narrow ACC_W=16 / K_LEN=2 instance for the saturation case.
module tb_systolic_mac_pe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        clear = 1'b0;
  logic [7:0]  a_in = '0;
  logic        a_valid_in = 1'b0;
  logic [7:0]  b_in = '0;
  logic        b_valid_in = 1'b0;
  logic [7:0]  a_out;
  logic        a_valid_out;
  logic [7:0]  b_out;
  logic        b_valid_out;
  logic [23:0] acc_out;
  logic        acc_valid;
  logic        overflow;
  logic        misalign;

  logic        clear_s = 1'b0;
  logic [7:0]  a_in_s = '0;
  logic        a_valid_in_s = 1'b0;
  logic [7:0]  b_in_s = '0;
  logic        b_valid_in_s = 1'b0;
  logic [7:0]  a_out_s;
  logic        a_valid_out_s;
  logic [7:0]  b_out_s;
  logic        b_valid_out_s;
  logic [15:0] acc_out_s;
  logic        acc_valid_s;
  logic        overflow_s;
  logic        misalign_s;

  int          n_chk = 0;
  int          n_fail = 0;

  int          pulse_cnt = 0;
  logic [23:0] cap_q[$];
  bit          dbl_pulse = 1'b0;
  logic        prev_valid = 1'b0;
  int          p0;

  always #5 clk = ~clk;

  systolic_mac_pe u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (clear),
    .a_in        (a_in),
    .a_valid_in  (a_valid_in),
    .b_in        (b_in),
    .b_valid_in  (b_valid_in),
    .a_out       (a_out),
    .a_valid_out (a_valid_out),
    .b_out       (b_out),
    .b_valid_out (b_valid_out),
    .acc_out     (acc_out),
    .acc_valid   (acc_valid),
    .overflow    (overflow),
    .misalign    (misalign)
  );

  systolic_mac_pe #(.ACC_W(16), .K_LEN(2)) u_dut_sat (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (clear_s),
    .a_in        (a_in_s),
    .a_valid_in  (a_valid_in_s),
    .b_in        (b_in_s),
    .b_valid_in  (b_valid_in_s),
    .a_out       (a_out_s),
    .a_valid_out (a_valid_out_s),
    .b_out       (b_out_s),
    .b_valid_out (b_valid_out_s),
    .acc_out     (acc_out_s),
    .acc_valid   (acc_valid_s),
    .overflow    (overflow_s),
    .misalign    (misalign_s)
  );

  // Record every completed window of the default instance.
  always @(negedge clk) begin
    if (acc_valid) begin
      pulse_cnt++;
      cap_q.push_back(acc_out);
      if (prev_valid) dbl_pulse = 1'b1;
    end
    prev_valid = acc_valid;
  end

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] cap_at(input int i);
    if (i < cap_q.size()) return 32'(cap_q[i]);
    return 32'hDEAD_BEEF;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] a, input logic av, input logic [7:0] b, input logic bv);
    a_in       = a;
    a_valid_in = av;
    b_in       = b;
    b_valid_in = bv;
    tick();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(8'd0, 1'b0, 8'd0, 1'b0);
  endtask

  task automatic feed(input logic [7:0] a, input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) drive(a, 1'b1, b, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Reset held with random inputs
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a_in       = 8'($urandom);
      b_in       = 8'($urandom);
      a_valid_in = 1'($urandom);
      b_valid_in = 1'($urandom);
      clear      = 1'($urandom);
      tick();
    end
    chk_eq("rst_a_out", 32'(a_out), 32'd0);
    chk_eq("rst_b_out", 32'(b_out), 32'd0);
    chk_eq("rst_valids", 32'({a_valid_out, b_valid_out}), 32'd0);
    chk_eq("rst_acc_out", 32'(acc_out), 32'd0);
    chk_eq("rst_flags", 32'({acc_valid, overflow, misalign}), 32'd0);
    clear = 1'b0;
    a_in = '0; b_in = '0; a_valid_in = 1'b0; b_valid_in = 1'b0;
    rst_n = 1'b1;
    idle(2);
    chk_eq("post_rst_out", 32'({a_out, b_out, a_valid_out, b_valid_out}), 32'd0);
    chk_eq("post_rst_acc", 32'({acc_valid, overflow, misalign}), 32'd0);
    chk_eq("post_rst_acc_out", 32'(acc_out), 32'd0);

    // Forwarding, then clear so this pair never reaches the accumulator
    drive(8'h12, 1'b1, 8'h34, 1'b1);
    chk_eq("fwd_a_out", 32'(a_out), 32'h12);
    chk_eq("fwd_b_out", 32'(b_out), 32'h34);
    chk_eq("fwd_valids", 32'({a_valid_out, b_valid_out}), 32'b11);
    clear = 1'b1;
    idle(1);
    clear = 1'b0;
    idle(3);
    chk_eq("fwd_cleared_no_pulse", 32'(pulse_cnt), 32'd0);

    // Full window 9 x (255*255), pulse on the third edge after the last pair
    feed(8'd255, 8'd255, 9);
    idle(1);
    chk_eq("full_lat_early", 32'(acc_valid), 32'd0);
    idle(1);
    chk_eq("full_lat_pulse", 32'(acc_valid), 32'd1);
    chk_eq("full_acc_out", 32'(acc_out), 32'd585225);
    chk_eq("full_overflow", 32'(overflow), 32'd0);
    idle(1);
    chk_eq("full_pulse_width", 32'(acc_valid), 32'd0);
    chk_eq("full_acc_held", 32'(acc_out), 32'd585225);

    // Bubbles, then a back-to-back window
    cap_q.delete();
    for (int i = 0; i < 9; i++) begin
      drive(8'd3, 1'b1, 8'd4, 1'b1);
      if (i < 8) idle(i % 3);
    end
    feed(8'd1, 8'd1, 9);
    idle(4);
    chk_eq("b2b_windows", 32'(cap_q.size()), 32'd2);
    chk_eq("bubble_sum", cap_at(0), 32'd108);
    chk_eq("b2b_sum", cap_at(1), 32'd9);
    chk_eq("b2b_single_cycle", 32'(dbl_pulse), 32'd0);

    // Saturation on the narrow instance
    a_in_s = 8'd255; b_in_s = 8'd255; a_valid_in_s = 1'b1; b_valid_in_s = 1'b1;
    tick();
    tick();
    a_valid_in_s = 1'b0; b_valid_in_s = 1'b0;
    tick();
    chk_eq("sat_lat_early", 32'(acc_valid_s), 32'd0);
    tick();
    chk_eq("sat_pulse", 32'(acc_valid_s), 32'd1);
    chk_eq("sat_acc_out", 32'(acc_out_s), 32'd65535);
    chk_eq("sat_overflow", 32'(overflow_s), 32'd1);
    tick();
    tick();
    chk_eq("sat_overflow_sticky", 32'(overflow_s), 32'd1);
    clear_s = 1'b1;
    tick();
    clear_s = 1'b0;
    chk_eq("sat_overflow_cleared", 32'(overflow_s), 32'd0);
    chk_eq("sat_acc_out_held", 32'(acc_out_s), 32'd65535);

    // Abort by clear after 4 terms; operands in the clear cycle forwarded only
    p0 = pulse_cnt;
    feed(8'd2, 8'd5, 4);
    idle(2);
    clear = 1'b1;
    drive(8'd7, 1'b1, 8'd7, 1'b1);
    clear = 1'b0;
    chk_eq("clr_fwd_a", 32'(a_out), 32'd7);
    chk_eq("clr_fwd_valid", 32'(a_valid_out), 32'd1);
    idle(3);
    chk_eq("clr_no_pulse", 32'(pulse_cnt), 32'(p0));
    chk_eq("clr_acc_out_held", 32'(acc_out), 32'd9);
    cap_q.delete();
    feed(8'd2, 8'd5, 9);
    idle(3);
    chk_eq("clr_next_windows", 32'(cap_q.size()), 32'd1);
    chk_eq("clr_next_sum", cap_at(0), 32'd90);

    // Abort by async reset after 4 terms
    feed(8'd2, 8'd5, 4);
    idle(2);
    p0 = pulse_cnt;
    rst_n = 1'b0;
    #1;
    chk_eq("arst_acc_out", 32'(acc_out), 32'd0);
    chk_eq("arst_fwd", 32'({a_out, a_valid_out}), 32'd0);
    tick();
    rst_n = 1'b1;
    idle(3);
    chk_eq("arst_no_pulse", 32'(pulse_cnt), 32'(p0));
    cap_q.delete();
    feed(8'd2, 8'd5, 9);
    idle(3);
    chk_eq("arst_next_sum", cap_at(0), 32'd90);

    // Misaligned valids inside a window
    chk_eq("mis_initial", 32'(misalign), 32'd0);
    cap_q.delete();
    feed(8'd2, 8'd5, 4);
    drive(8'd9, 1'b1, 8'd9, 1'b0);
    chk_eq("mis_fwd_b_out", 32'(b_out), 32'd9);
    chk_eq("mis_fwd_valids", 32'({a_valid_out, b_valid_out}), 32'b10);
    chk_eq("mis_flag", 32'(misalign), 32'd1);
    feed(8'd2, 8'd5, 5);
    idle(3);
    chk_eq("mis_windows", 32'(cap_q.size()), 32'd1);
    chk_eq("mis_sum", cap_at(0), 32'd90);
    chk_eq("mis_sticky", 32'(misalign), 32'd1);
    clear = 1'b1;
    idle(1);
    clear = 1'b0;
    chk_eq("mis_cleared", 32'(misalign), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
